tile_render_pipeline: RTL and testbench
=======================================

// Module: tile_render_pipeline
// PURPOSE
//  Pixel-generation stage directly downstream of the 640x480 VGA timing generator.
//  Consumes drawX/drawY/active_nblank/hs/vs, fetches a 40x30 tilemap of 16x16 tiles
//  from external sync BRAMs, maps 4-bit colour indices through a 16-entry palette.
//  Emits 4:4:4 RGB plus hs/vs/blank delayed to match, ready for the HDMI encoder.
//  Hardware scroll registers are written by the CPU and applied once per frame.
// PARAMETERS
//  H_ACTIVE   640  active pixels per line (scroll-x wrap modulus)
//  V_ACTIVE   480  active lines per frame (scroll-y wrap modulus)
//  PIPE_LAT   3    drawX/Y -> RGB latency in pixel_clk cycles (fixed; not tunable)
// PORTS
//  pixel_clk      in   1   pixel clock
//  reset          in   1   asynchronous, active-high reset
//  drawX, drawY   in   10  current pixel coordinate from timing generator
//  active_nblank  in   1   1 = active video
//  hs_in, vs_in   in   1   registered syncs from timing generator, active low
//  map_addr       out  11  tilemap BRAM address (row*40+col)
//  map_data       in   8   tile index, valid 1 cycle after map_addr
//  pix_addr       out  16  tile pixel ROM address {tile[7:0],py[3:0],px[3:0]}
//  pix_data       in   4   colour index, valid 1 cycle after pix_addr
//  reg_we         in   1   CPU register write strobe (single cycle)
//  reg_addr       in   5   register select
//  reg_wdata      in   16  write data
//  red,green,blue out  4   pixel colour (each)
//  hs_out, vs_out out  1   syncs delayed PIPE_LAT cycles, active low
//  nblank_out     out  1   active_nblank delayed PIPE_LAT cycles
//  frame_start    out  1   1-cycle pulse at start of vertical blank
//  frame_count    out  16  frames since reset; wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: all outputs 0 except hs_out=vs_out=1; palette=0, scroll shadow/active=0, ctrl=0.
//   Pipeline regs cleared; reset mid-frame drops the in-flight pixels, no partial output.
//  Registers: 0-15 palette[i] <= wdata[11:0] (RGB444), effective immediately.
//   16 scroll_x shadow, 17 scroll_y shadow: wdata[9:0]; write ignored if >= H_ACTIVE/V_ACTIVE.
//   18 ctrl: [0]=enable, [12:1]=bg_rgb. Other addresses ignored.
//  Frame boundary = cycle with drawX==0 && drawY==V_ACTIVE: active scroll <= shadow,
//   frame_start=1, frame_count++. A shadow write in that same cycle lands in the shadow;
//   active takes the pre-write shadow value; the new value applies next frame.
//  Stage 0: wx=drawX+scroll_x, minus H_ACTIVE if >= H_ACTIVE (11-bit sum, no overflow);
//   wy likewise with V_ACTIVE. map_addr=(wy>>4)*40+(wx>>4) via (r<<5)+(r<<3).
//  Stage 1: map_data valid; pix_addr={map_data,wy[3:0],wx[3:0]} (wx/wy piped).
//  Stage 2: pix_data valid; palette lookup. Index 0 = transparent -> bg_rgb.
//  Stage 3: registered output. nblank_d=0 -> RGB=0. enable=0 -> bg_rgb in active area.
//  hs/vs/nblank pass through a 3-deep shift register; exactly aligned with RGB.
//  Addresses are issued during blanking too (harmless; output gated by nblank).
// STRUCTURE
//  Package tile_render_pkg: H_ACTIVE, V_ACTIVE, TILE_SZ=16, MAP_COLS=40, MAP_ROWS=30,
//   register address constants, typedef rgb444_t {r,g,b}.
//  Sub-module tile_palette: 16x12 regfile, one write port, one combinational read port.
// TESTING
//  1 Scroll 0, map[0]=5, pix ROM(5,py=0,px=0)=3, palette[3]=0xF00; drawX=drawY=0
//    -> 3 cycles later red=F, green=0, blue=0, nblank_out=1.
//  2 scroll_x=630 applied; drawX=20 -> wx=10 (wrap), map_addr col 0; drawX=9 -> wx=639, col 39.
//  3 Write scroll_x=700 -> ignored, shadow keeps old; write at frame-boundary cycle
//    -> effective only after the next frame_start.
//  4 Colour index 0 with bg_rgb=0x0A5 -> RGB=0x0A5; enable=0 -> bg everywhere active;
//    blanking (drawX=700) -> RGB=0.
//  5 Sync alignment: hs_in falls at cycle N -> hs_out falls at N+3; same for vs/nblank.
//  6 Assert reset mid-line -> outputs immediately RGB=0, hs_out=vs_out=1, frame_count=0;
//    after release, first valid pixel 3 cycles after first active drawX.

Source files
------------

// File: rtl/tile_render_pkg.sv
// Shared constants and types for the tile renderer: screen geometry, register map,
// and the RGB444 colour type used by the palette and output stage.
package tile_render_pkg;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int TILE_SZ  = 16;
  localparam int MAP_COLS = 40;
  localparam int MAP_ROWS = 30;
  localparam int PIPE_LAT = 3;

  localparam logic [4:0] REG_SCROLL_X = 5'd16;
  localparam logic [4:0] REG_SCROLL_Y = 5'd17;
  localparam logic [4:0] REG_CTRL     = 5'd18;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Bit 0 is enable, bits 12:1 the background colour, matching the register layout.
  typedef struct packed {
    rgb444_t bg;
    logic    enable;
  } ctrl_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic nb;
  } sync_t;

  // Modular add of a screen coordinate and a scroll offset (both already < modulus
  // in the active area, so one conditional subtract suffices).
  function automatic logic [9:0] wrap_add(input logic [9:0] a, input logic [9:0] b,
                                          input logic [10:0] modulus);
    logic [10:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= modulus) s = s - modulus;
    return s[9:0];
  endfunction
endpackage

// File: rtl/tile_render_if.sv
// Signal bundle between the VGA timing generator / BRAMs / CPU side and the renderer.
interface tile_render_if;
  logic [9:0]  drawX;
  logic [9:0]  drawY;
  logic        active_nblank;
  logic        hs_in;
  logic        vs_in;
  logic [10:0] map_addr;
  logic [7:0]  map_data;
  logic [15:0] pix_addr;
  logic [3:0]  pix_data;
  logic        reg_we;
  logic [4:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic        hs_out;
  logic        vs_out;
  logic        nblank_out;
  logic        frame_start;
  logic [15:0] frame_count;

  modport slave (
    input  drawX, drawY, active_nblank, hs_in, vs_in, map_data, pix_data,
           reg_we, reg_addr, reg_wdata,
    output map_addr, pix_addr, red, green, blue, hs_out, vs_out, nblank_out,
           frame_start, frame_count
  );

  modport master (
    output drawX, drawY, active_nblank, hs_in, vs_in, map_data, pix_data,
           reg_we, reg_addr, reg_wdata,
    input  map_addr, pix_addr, red, green, blue, hs_out, vs_out, nblank_out,
           frame_start, frame_count
  );
endinterface

// File: rtl/tile_palette.sv
// 16-entry RGB444 palette: one synchronous write port, one combinational read port.
module tile_palette
  import tile_render_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    we,
  input  logic [3:0] waddr,
  input  rgb444_t wdata,
  input  logic [3:0] raddr,
  output rgb444_t rdata
);
  rgb444_t mem [16];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/tile_render_pipeline.sv
// Tilemap pixel generator: scrolled map fetch, tile pixel fetch, palette lookup,
// registered RGB444 out with syncs delayed to stay aligned with the colour.
module tile_render_pipeline
  import tile_render_pkg::*;
(
  input  logic pixel_clk,
  input  logic reset,
  tile_render_if.slave bus
);
  logic [9:0]  sx_sh, sy_sh, sx_act, sy_act;
  ctrl_t       ctrl;
  logic        frame_edge;
  logic        frame_start_q;
  logic [15:0] frame_cnt_q;

  assign frame_edge = (bus.drawX == 10'd0) && (bus.drawY == 10'(V_ACTIVE));

  // CPU registers and per-frame scroll latch. A shadow write in the boundary cycle
  // lands in the shadow only; the active copy takes the pre-write value.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      sx_sh         <= '0;
      sy_sh         <= '0;
      sx_act        <= '0;
      sy_act        <= '0;
      ctrl          <= '0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      if (bus.reg_we) begin
        case (bus.reg_addr)
          REG_SCROLL_X: if (bus.reg_wdata[9:0] < 10'(H_ACTIVE)) sx_sh <= bus.reg_wdata[9:0];
          REG_SCROLL_Y: if (bus.reg_wdata[9:0] < 10'(V_ACTIVE)) sy_sh <= bus.reg_wdata[9:0];
          REG_CTRL:     ctrl <= ctrl_t'(bus.reg_wdata[12:0]);
          default: ;
        endcase
      end
      frame_start_q <= frame_edge;
      if (frame_edge) begin
        sx_act      <= sx_sh;
        sy_act      <= sy_sh;
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  // Palette writes are addresses 0-15, i.e. reg_addr[4] clear.
  rgb444_t pal_rd;
  tile_palette u_palette (
    .clk   (pixel_clk),
    .rst   (reset),
    .we    (bus.reg_we && !bus.reg_addr[4]),
    .waddr (bus.reg_addr[3:0]),
    .wdata (rgb444_t'(bus.reg_wdata[11:0])),
    .raddr (bus.pix_data),
    .rdata (pal_rd)
  );

  // Stage 0: scrolled world coordinate and map address (row*40 = row*32 + row*8).
  logic [9:0] wx, wy;
  logic [5:0] row, col;
  assign wx  = wrap_add(bus.drawX, sx_act, 11'(H_ACTIVE));
  assign wy  = wrap_add(bus.drawY, sy_act, 11'(V_ACTIVE));
  assign row = wy[9:4];
  assign col = wx[9:4];
  assign bus.map_addr = {row, 5'd0} + {2'd0, row, 3'd0} + {5'd0, col};

  // Stage 1: map_data arrives; in-tile offsets ride along one cycle.
  logic [3:0] px1, py1;
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      px1 <= '0;
      py1 <= '0;
    end else begin
      px1 <= wx[3:0];
      py1 <= wy[3:0];
    end
  end
  assign bus.pix_addr = {bus.map_data, py1, px1};

  // Sync/blank delay line; index k holds the value sampled k cycles ago.
  sync_t                sync_in;
  sync_t [PIPE_LAT:1]   sync_pipe;
  assign sync_in = '{hs: bus.hs_in, vs: bus.vs_in, nb: bus.active_nblank};

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i <= PIPE_LAT; i++) sync_pipe[i] <= '{hs: 1'b1, vs: 1'b1, nb: 1'b0};
    end else begin
      sync_pipe <= {sync_pipe[PIPE_LAT-1:1], sync_in};
    end
  end

  // Stage 2: pix_data arrives; index 0 is transparent, disabled output shows bg.
  rgb444_t pix_rgb, rgb_next, rgb_q;
  always_comb begin
    pix_rgb  = pal_rd;
    if (!ctrl.enable || bus.pix_data == 4'd0) pix_rgb = ctrl.bg;
    rgb_next = sync_pipe[PIPE_LAT-1].nb ? pix_rgb : '0;
  end

  // Stage 3: registered output, lands in the same cycle as sync_pipe[PIPE_LAT].
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) rgb_q <= '0;
    else       rgb_q <= rgb_next;
  end

  logic unused_wdata;
  assign unused_wdata = ^bus.reg_wdata[15:13];

  assign bus.red         = rgb_q.r;
  assign bus.green       = rgb_q.g;
  assign bus.blue        = rgb_q.b;
  assign bus.hs_out      = sync_pipe[PIPE_LAT].hs;
  assign bus.vs_out      = sync_pipe[PIPE_LAT].vs;
  assign bus.nblank_out  = sync_pipe[PIPE_LAT].nb;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_count = frame_cnt_q;
endmodule

// File: tb/tb_tile_render_pipeline.sv
// Directed bench for tile_render_pipeline with behavioural sync BRAMs for map and pixels.
module tb_tile_render_pipeline;
  import tile_render_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tile_render_if bus ();
  tile_render_pipeline dut (.pixel_clk(clk), .reset(rst), .bus(bus));

  logic [7:0] map_mem [0:2047];
  logic [3:0] pix_rom [0:65535];
  always @(posedge clk) begin
    bus.map_data <= map_mem[bus.map_addr];
    bus.pix_data <= pix_rom[bus.pix_addr];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reg_wr(input logic [4:0] a, input logic [15:0] d);
    bus.reg_we    = 1'b1;
    bus.reg_addr  = a;
    bus.reg_wdata = d;
    tick(1);
    bus.reg_we    = 1'b0;
  endtask

  task automatic set_pix(input int x, input int y, input logic nb);
    bus.drawX         = 10'(x);
    bus.drawY         = 10'(y);
    bus.active_nblank = nb;
  endtask

  function automatic logic [11:0] rgb_out();
    return {bus.red, bus.green, bus.blue};
  endfunction

  typedef struct {
    int          x;
    int          y;
    logic        nb;
    logic [10:0] maddr;
    logic [11:0] rgb;
  } vec_t;
  vec_t vt [5];

  initial begin
    vt[0] = '{x: 0,   y: 0,   nb: 1'b1, maddr: 11'd0,    rgb: 12'hF00};
    vt[1] = '{x: 17,  y: 2,   nb: 1'b1, maddr: 11'd1,    rgb: 12'h3C7};
    vt[2] = '{x: 639, y: 479, nb: 1'b1, maddr: 11'd1199, rgb: 12'h0A5};
    vt[3] = '{x: 700, y: 10,  nb: 1'b0, maddr: 11'd3,    rgb: 12'h000};
    vt[4] = '{x: 320, y: 240, nb: 1'b1, maddr: 11'd620,  rgb: 12'hFFF};

    for (int i = 0; i < 2048; i++) map_mem[i] = 8'h00;
    for (int i = 0; i < 65536; i++) pix_rom[i] = 4'h0;
    map_mem[0]    = 8'h05;  pix_rom[{8'h05, 4'h0, 4'h0}] = 4'h3;
    map_mem[1]    = 8'h07;  pix_rom[{8'h07, 4'h2, 4'h1}] = 4'h9;
    map_mem[1199] = 8'hAB;
    map_mem[620]  = 8'h11;  pix_rom[{8'h11, 4'h0, 4'h0}] = 4'hF;
    map_mem[39]   = 8'h22;  pix_rom[{8'h22, 4'h0, 4'hF}] = 4'h4;

    bus.reg_we = 1'b0; bus.reg_addr = '0; bus.reg_wdata = '0;
    bus.hs_in = 1'b1; bus.vs_in = 1'b1;
    set_pix(0, 0, 1'b0);

    #12;
    chk("reset_rgb", 32'(rgb_out()), 32'h0);
    chk("reset_hs", 32'(bus.hs_out), 32'h1);
    chk("reset_vs", 32'(bus.vs_out), 32'h1);
    chk("reset_nblank", 32'(bus.nblank_out), 32'h0);
    chk("reset_fstart", 32'(bus.frame_start), 32'h0);
    chk("reset_fcount", 32'(bus.frame_count), 32'h0);
    @(negedge clk) rst = 1'b0;
    tick(1);

    reg_wr(5'd3,  16'h0F00);
    reg_wr(5'd9,  16'h03C7);
    reg_wr(5'd4,  16'h0123);
    reg_wr(5'd15, 16'h0FFF);
    reg_wr(REG_CTRL, {3'b0, 12'h0A5, 1'b1});

    for (int i = 0; i < 5; i++) begin
      set_pix(vt[i].x, vt[i].y, vt[i].nb);
      #1;
      chk($sformatf("vec%0d_map_addr", i), 32'(bus.map_addr), 32'(vt[i].maddr));
      tick(3);
      chk($sformatf("vec%0d_rgb", i), 32'(rgb_out()), 32'(vt[i].rgb));
      chk($sformatf("vec%0d_nblank", i), 32'(bus.nblank_out), 32'(vt[i].nb));
    end

    // Disabled: bg across the active area regardless of map content.
    reg_wr(REG_CTRL, {3'b0, 12'h0A5, 1'b0});
    set_pix(0, 0, 1'b1);
    tick(3);
    chk("disabled_bg", 32'(rgb_out()), 32'h0A5);
    reg_wr(REG_CTRL, {3'b0, 12'h0A5, 1'b1});
    tick(3);
    chk("reenabled_pix", 32'(rgb_out()), 32'hF00);

    // Shadow written but not yet applied.
    reg_wr(REG_SCROLL_X, 16'd630);
    reg_wr(REG_SCROLL_Y, 16'd470);
    set_pix(20, 10, 1'b1);
    #1;
    chk("pre_frame_map_addr", 32'(bus.map_addr), 32'd1);

    set_pix(0, 480, 1'b0);
    tick(1);
    chk("frame1_start", 32'(bus.frame_start), 32'h1);
    chk("frame1_count", 32'(bus.frame_count), 32'd1);
    set_pix(20, 10, 1'b1);
    #1;
    chk("wrap_x_col0", 32'(bus.map_addr), 32'd0);
    tick(1);
    chk("frame_start_pulse_end", 32'(bus.frame_start), 32'h0);
    set_pix(9, 9, 1'b1);
    #1;
    chk("wrap_xy_last", 32'(bus.map_addr), 32'd1199);
    set_pix(9, 10, 1'b1);
    #1;
    chk("wrap_x_col39", 32'(bus.map_addr), 32'd39);
    tick(3);
    chk("wrap_x_col39_rgb", 32'(rgb_out()), 32'h123);

    // Out-of-range writes leave the shadow unchanged.
    reg_wr(REG_SCROLL_X, 16'd700);
    reg_wr(REG_SCROLL_Y, 16'd500);
    set_pix(0, 480, 1'b0);
    tick(1);
    chk("frame2_count", 32'(bus.frame_count), 32'd2);
    set_pix(20, 10, 1'b1);
    #1;
    chk("ignored_scroll", 32'(bus.map_addr), 32'd0);

    // Shadow write in the boundary cycle applies one frame later.
    set_pix(0, 480, 1'b0);
    bus.reg_we = 1'b1; bus.reg_addr = REG_SCROLL_X; bus.reg_wdata = 16'd16;
    tick(1);
    bus.reg_we = 1'b0;
    chk("frame3_count", 32'(bus.frame_count), 32'd3);
    set_pix(20, 10, 1'b1);
    #1;
    chk("boundary_write_deferred", 32'(bus.map_addr), 32'd0);
    tick(1);
    set_pix(0, 480, 1'b0);
    tick(1);
    chk("frame4_count", 32'(bus.frame_count), 32'd4);
    set_pix(20, 10, 1'b1);
    #1;
    chk("boundary_write_applied", 32'(bus.map_addr), 32'd2);

    // Sync alignment: (5,10) maps to a transparent pixel, so bg until blank arrives.
    set_pix(5, 10, 1'b1);
    tick(3);
    bus.hs_in = 1'b0; bus.vs_in = 1'b0; bus.active_nblank = 1'b0;
    tick(1);
    chk("hs_n1", 32'(bus.hs_out), 32'h1);
    tick(1);
    chk("hs_n2", 32'(bus.hs_out), 32'h1);
    chk("vs_n2", 32'(bus.vs_out), 32'h1);
    chk("rgb_n2", 32'(rgb_out()), 32'h0A5);
    tick(1);
    chk("hs_n3", 32'(bus.hs_out), 32'h0);
    chk("vs_n3", 32'(bus.vs_out), 32'h0);
    chk("nblank_n3", 32'(bus.nblank_out), 32'h0);
    chk("rgb_n3", 32'(rgb_out()), 32'h0);

    // Reset mid-line with pixels in flight and hs_out low.
    set_pix(20, 10, 1'b1);
    tick(3);
    chk("pre_reset_rgb", 32'(rgb_out()), 32'h0A5);
    rst = 1'b1;
    #1;
    chk("midreset_rgb", 32'(rgb_out()), 32'h0);
    chk("midreset_hs", 32'(bus.hs_out), 32'h1);
    chk("midreset_vs", 32'(bus.vs_out), 32'h1);
    chk("midreset_fcount", 32'(bus.frame_count), 32'h0);
    bus.hs_in = 1'b1; bus.vs_in = 1'b1;
    set_pix(20, 10, 1'b0);
    @(negedge clk) rst = 1'b0;
    tick(1);
    set_pix(20, 10, 1'b1);
    #1;
    chk("post_reset_scroll0", 32'(bus.map_addr), 32'd1);
    tick(1);
    chk("post_reset_nb1", 32'(bus.nblank_out), 32'h0);
    tick(1);
    chk("post_reset_nb2", 32'(bus.nblank_out), 32'h0);
    tick(1);
    chk("post_reset_nb3", 32'(bus.nblank_out), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
